// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory access path.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  localparam int unsigned MEM_SIZE_DEFAULT = 32'd1024;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_DATA = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  function automatic logic [3:0] bytes_of(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 4'd1;
      SZ_HALF: return 4'd2;
      SZ_WORD: return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return (off[1:0] != 2'd0);
      default: return (off != 3'd0);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane extraction/extension for loads and lane merge for sub-dword stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] store_data
);

  logic [63:0] shifted_s;
  logic [63:0] mask_s;
  logic [6:0]  pos_s;

  // Field sits at the top after shifting by off bytes; pos_s is the field LSB in the dword.
  always_comb begin
    shifted_s = dword << {off, 3'b000};
    pos_s     = 7'd64 - {1'b0, off, 3'b000} - {bytes_of(size), 3'b000};
    mask_s    = {64{1'b1}};
    load_data = shifted_s;
    case (size)
      SZ_BYTE: begin
        mask_s    = 64'h0000_0000_0000_00ff;
        load_data = {{56{sign_ext & shifted_s[63]}}, shifted_s[63:56]};
      end
      SZ_HALF: begin
        mask_s    = 64'h0000_0000_0000_ffff;
        load_data = {{48{sign_ext & shifted_s[63]}}, shifted_s[63:48]};
      end
      SZ_WORD: begin
        mask_s    = 64'h0000_0000_ffff_ffff;
        load_data = {{32{sign_ext & shifted_s[63]}}, shifted_s[63:32]};
      end
      default: begin
        mask_s    = {64{1'b1}};
        load_data = shifted_s;
      end
    endcase
    store_data = (dword & ~(mask_s << pos_s)) | ((wdata & mask_s) << pos_s);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator adapting byte/half/word/dword accesses to a dword-wide,
// 1-cycle registered-read memory, with read-modify-write for narrow stores.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEFAULT
)(
  input  logic        Clock,
  input  logic        ResetL,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic [63:0] MemAddress,
  output logic [63:0] MemWriteData,
  output logic        MemoryRead,
  output logic        MemoryWrite,
  input  logic [63:0] MemReadData
);

  state_t      state_r;
  logic        write_r;
  logic [1:0]  size_r;
  logic        sign_r;
  logic [2:0]  off_r;
  logic [63:0] wdata_r;

  logic [63:0] base_s;
  logic [64:0] last_byte_s;
  logic        err_s;
  logic [63:0] load_data_s;
  logic [63:0] store_data_s;

  // Request decode; the 65-bit sum keeps addresses near the top of the space out of range.
  always_comb begin
    base_s      = {req_addr[63:3], 3'b000};
    last_byte_s = {1'b0, base_s} + 65'd7;
    err_s       = misaligned(req_size, req_addr[2:0]) || (last_byte_s >= 65'(MEM_SIZE));
  end

  mem_lane_align u_lane (
    .dword      (MemReadData),
    .off        (off_r),
    .size       (size_r),
    .sign_ext   (sign_r),
    .wdata      (wdata_r),
    .load_data  (load_data_s),
    .store_data (store_data_s)
  );

  // Access sequencer with registered strobes and response.
  always_ff @(posedge Clock or negedge ResetL) begin
    if (!ResetL) begin
      state_r      <= ST_IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_error    <= 1'b0;
      rsp_rdata    <= 64'd0;
      MemoryRead   <= 1'b0;
      MemoryWrite  <= 1'b0;
      MemAddress   <= 64'd0;
      MemWriteData <= 64'd0;
      write_r      <= 1'b0;
      size_r       <= 2'd0;
      sign_r       <= 1'b0;
      off_r        <= 3'd0;
      wdata_r      <= 64'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            write_r   <= req_write;
            size_r    <= req_size;
            sign_r    <= req_signed;
            off_r     <= req_addr[2:0];
            wdata_r   <= req_wdata;
            if (err_s) begin
              state_r   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= 64'd0;
            end else if (req_write && (req_size == SZ_DWORD)) begin
              state_r      <= ST_WR;
              MemoryWrite  <= 1'b1;
              MemAddress   <= base_s;
              MemWriteData <= req_wdata;
            end else begin
              state_r    <= ST_RD;
              MemoryRead <= 1'b1;
              MemAddress <= base_s;
            end
          end
        end
        ST_RD: begin
          MemoryRead <= 1'b0;
          state_r    <= ST_DATA;
        end
        ST_DATA: begin
          if (write_r) begin
            state_r      <= ST_WR;
            MemoryWrite  <= 1'b1;
            MemWriteData <= store_data_s;
          end else begin
            state_r   <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data_s;
          end
        end
        ST_WR: begin
          MemoryWrite <= 1'b0;
          state_r     <= ST_RESP;
          rsp_valid   <= 1'b1;
          rsp_rdata   <= 64'd0;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r   <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= 64'd0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          req_ready   <= 1'b1;
          rsp_valid   <= 1'b0;
          rsp_error   <= 1'b0;
          MemoryRead  <= 1'b0;
          MemoryWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-array reference model.
module tb_mem_access_unit;

  localparam int MEM_SIZE = 1024;

  logic        Clock = 1'b0;
  logic        ResetL = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, rsp_ready = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic        req_ready, rsp_valid, rsp_error, MemoryRead, MemoryWrite;
  logic [63:0] rsp_rdata, MemAddress, MemWriteData, MemReadData;

  always #5 Clock = ~Clock;

  mem_access_unit #(.MEM_SIZE(MEM_SIZE)) dut (
    .Clock(Clock), .ResetL(ResetL),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .MemReadData(MemReadData)
  );

  logic [63:0] la_dword = 64'd0, la_wdata = 64'd0, la_load, la_store;
  logic [2:0]  la_off = 3'd0;
  logic [1:0]  la_size = 2'd0;
  logic        la_sign = 1'b0;

  mem_lane_align u_lane_chk (
    .dword(la_dword), .off(la_off), .size(la_size), .sign_ext(la_sign),
    .wdata(la_wdata), .load_data(la_load), .store_data(la_store)
  );

  logic [7:0]  ref_mem [0:MEM_SIZE-1];
  logic [63:0] init_img [0:MEM_SIZE/8-1];
  logic [63:0] dmem [0:MEM_SIZE/8-1];
  logic        mem_load = 1'b1;

  // Memory: registered read, whole-dword write at the strobe edge.
  always @(posedge Clock) begin
    if (mem_load) begin
      for (int i = 0; i < MEM_SIZE/8; i++) dmem[i] <= init_img[i];
    end else begin
      if (MemoryRead) MemReadData <= dmem[MemAddress[9:3]];
      if (MemoryWrite) dmem[MemAddress[9:3]] <= MemWriteData;
    end
  end

  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  logic [63:0] last_addr = 64'd0, last_wdata = 64'd0;

  always @(negedge Clock) begin
    if (MemoryRead) begin rd_cnt++; last_addr = MemAddress; end
    if (MemoryWrite) begin wr_cnt++; last_addr = MemAddress; last_wdata = MemWriteData; end
    if (MemoryRead && MemoryWrite) both_cnt++;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [63:0] extend(input logic [63:0] v, input int n, input bit sgn);
    logic [63:0] r;
    r = v;
    if (sgn && n < 8 && v[8*n-1]) r = r | (~64'd0 << (8*n));
    return r;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input int n, input bit sgn);
    logic [63:0] v;
    v = 64'd0;
    for (int k = 0; k < n; k++) v = (v << 8) | {56'd0, ref_mem[a+k]};
    return extend(v, n, sgn);
  endfunction

  function automatic logic [63:0] field_of(input logic [63:0] d, input int off, input int n, input bit sgn);
    logic [63:0] v;
    v = 64'd0;
    for (int k = 0; k < n; k++) v = (v << 8) | {56'd0, d[63-8*(off+k) -: 8]};
    return extend(v, n, sgn);
  endfunction

  function automatic logic [63:0] merge_of(input logic [63:0] d, input int off, input int n, input logic [63:0] w);
    logic [63:0] r;
    r = d;
    for (int k = 0; k < n; k++) r[63-8*(off+k) -: 8] = w[8*(n-1-k) +: 8];
    return r;
  endfunction

  task automatic wait_idle();
    int c;
    c = 0;
    while (!req_ready && c < 20) begin @(negedge Clock); c++; end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
  endtask

  task automatic do_access(input bit wr, input logic [1:0] sz, input bit sgn,
                           input logic [63:0] addr, input logic [63:0] wd, input int hold,
                           output logic [63:0] got);
    int n, lat, cyc, exp_rds, exp_wrs;
    bit err;
    logic [63:0] base, exp_rd;
    n       = 1 << sz;
    base    = addr & ~64'd7;
    err     = (addr % n != 0) || (base + 7 >= MEM_SIZE);
    lat     = err ? 1 : (wr ? (n == 8 ? 2 : 4) : 3);
    exp_rd  = (err || wr) ? 64'd0 : ref_load(addr, n, sgn);
    exp_rds = (err || (wr && n == 8)) ? 0 : 1;
    exp_wrs = (!err && wr) ? 1 : 0;
    wait_idle();
    req_write = wr; req_size = sz; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge Clock);
    #1 req_valid = 1'b0;
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
    cyc = 0;
    do begin @(negedge Clock); cyc++; end while (!rsp_valid && cyc < 20);
    chk("latency", 64'(cyc), 64'(lat));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_error", 64'(rsp_error), 64'(err));
    got = rsp_rdata;
    // A conflicting request offered while the response waits must be ignored.
    req_write = 1'b1; req_size = 2'd3; req_addr = 64'd0; req_wdata = ~64'd0;
    req_valid = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge Clock);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge Clock);
    #1 rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge Clock);
    chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rd_strobes", 64'(rd_cnt), 64'(exp_rds));
    chk("wr_strobes", 64'(wr_cnt), 64'(exp_wrs));
    chk("both_strobes", 64'(both_cnt), 64'd0);
    if (exp_rds + exp_wrs > 0) chk("mem_addr", last_addr, base);
    if (!err && wr) begin
      for (int k = 0; k < n; k++) ref_mem[addr+k] = wd[8*(n-1-k) +: 8];
      chk("mem_wdata", last_wdata, ref_load(base, 8, 1'b0));
    end
  endtask

  task automatic reset_in_wr();
    int c;
    logic [63:0] pre;
    pre = ref_load(64'h18, 8, 1'b0);
    wait_idle();
    req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0; req_addr = 64'h1a; req_wdata = 64'h1234;
    req_valid = 1'b1;
    @(posedge Clock);
    #1 req_valid = 1'b0;
    c = 0;
    do begin @(negedge Clock); c++; end while (!MemoryWrite && c < 10);
    chk("rst_wr_cycle", 64'(c), 64'd3);
    ResetL = 1'b0;
    #1;
    chk("rst_mem_write", 64'(MemoryWrite), 64'd0);
    chk("rst_mem_read", 64'(MemoryRead), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_mem_addr", MemAddress, 64'd0);
    chk("rst_mem_wdata", MemWriteData, 64'd0);
    @(posedge Clock);
    #1 chk("rst_mem_unchanged", dmem[3], pre);
    @(negedge Clock);
    ResetL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] got, pre, d, w, a;
    int n, off, mism;
    bit wr, sg;
    logic [1:0] sz;
    pre = 64'h0ffbea7deadbeeff;
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 8; k++) ref_mem[24+k] = pre[63-8*k -: 8];
    for (int i = 0; i < MEM_SIZE/8; i++) init_img[i] = ref_load(64'(8*i), 8, 1'b0);

    #1 ResetL = 1'b0;
    #2;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_rdata", rsp_rdata, 64'd0);
    chk("reset_strobes", {62'd0, MemoryRead, MemoryWrite}, 64'd0);
    chk("reset_mem_addr", MemAddress, 64'd0);

    // Standalone lane aligner against byte-wise extraction/merge.
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3)); n = 1 << sz;
      off = $urandom_range(0, 7) & ~(n - 1);
      d = {$urandom, $urandom}; w = {$urandom, $urandom}; sg = 1'($urandom_range(0, 1));
      la_dword = d; la_wdata = w; la_size = sz; la_off = 3'(off); la_sign = sg;
      #1;
      chk("lane_load", la_load, field_of(d, off, n, sg));
      chk("lane_store", la_store, merge_of(d, off, n, w));
    end

    @(negedge Clock); @(negedge Clock);
    mem_load = 1'b0;
    ResetL = 1'b1;
    @(negedge Clock);

    chk("model_pin_dword", ref_load(64'h18, 8, 1'b0), 64'h0ffbea7deadbeeff);
    do_access(1'b0, 2'd3, 1'b0, 64'h18, 64'd0, 0, got);
    chk("pin_dword_load", got, 64'h0ffbea7deadbeeff);
    do_access(1'b0, 2'd0, 1'b1, 64'h1c, 64'd0, 0, got);
    chk("pin_byte_signed", got, 64'hffffffffffffffea);
    do_access(1'b0, 2'd0, 1'b0, 64'h1c, 64'd0, 0, got);
    chk("pin_byte_unsigned", got, 64'h00000000000000ea);
    do_access(1'b0, 2'd2, 1'b1, 64'h1c, 64'd0, 0, got);
    chk("pin_word_signed", got, 64'hffffffffeadbeeff);
    do_access(1'b1, 2'd1, 1'b0, 64'h1a, 64'h000000000000abcd, 0, got);
    chk("pin_half_store_wdata", last_wdata, 64'h0ffbabcdeadbeeff);
    do_access(1'b0, 2'd3, 1'b0, 64'h18, 64'd0, 0, got);
    chk("pin_after_store", got, 64'h0ffbabcdeadbeeff);
    do_access(1'b0, 2'd2, 1'b0, 64'h1a, 64'd0, 0, got);
    do_access(1'b0, 2'd3, 1'b0, 64'h400, 64'd0, 0, got);
    do_access(1'b0, 2'd3, 1'b0, 64'h3f8, 64'd0, 0, got);
    do_access(1'b0, 2'd2, 1'b1, 64'h18, 64'd0, 4, got);
    do_access(1'b1, 2'd3, 1'b0, 64'h40, 64'h0123456789abcdef, 0, got);
    do_access(1'b0, 2'd3, 1'b0, 64'h40, 64'd0, 0, got);
    chk("pin_dword_store", got, 64'h0123456789abcdef);

    reset_in_wr();

    for (int i = 0; i < 80; i++) begin
      sz = 2'($urandom_range(0, 3)); n = 1 << sz;
      a = 64'($urandom_range(0, 1100));
      if ($urandom_range(0, 3) != 0) a = a & ~64'(n - 1);
      wr = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      do_access(wr, sz, sg, a, {$urandom, $urandom}, $urandom_range(0, 2), got);
    end

    mism = 0;
    for (int i = 0; i < MEM_SIZE/8; i++)
      if (dmem[i] !== ref_load(64'(8*i), 8, 1'b0)) mism++;
    chk("final_memory", 64'(mism), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
